// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-pin synchronizer and debounce filter, edge capture
// with selectable polarity, masked level interrupt, 4-word Avalon-MM register slave.
module gpio_input_conditioner #(
    parameter int unsigned WIDTH           = 28,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE   = 2'd0;
    localparam logic [1:0] ADDR_EDGECAP = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgesel_q, edgesel_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;

    // Synchronizer shift chain
    always_comb begin
        sync_d[0] = pin_in;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Per-bit debounce: a change is accepted only after persisting DEBOUNCE_CYCLES edges
    always_comb begin
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_out[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync_out[i];
                cnt_d[i]    = '0;
                accept[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Register file, edge capture (set beats clear) and read mux
    always_comb begin
        wr_en     = chipselect && !write_n;
        cap_set   = (accept & ~stable_q & ~edgesel_q) | (accept & stable_q & edgesel_q);
        cap_clr   = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~cap_clr) | cap_set;
        irqmask_d = (wr_en && (address == ADDR_IRQMASK)) ? writedata[WIDTH-1:0] : irqmask_q;
        edgesel_d = (wr_en && (address == ADDR_EDGESEL)) ? writedata[WIDTH-1:0] : edgesel_q;
        irq_d     = |(edgecap_q & irqmask_q);
        case (address)
            ADDR_STATE:   readdata_d = 32'(stable_q);
            ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
            default:      readdata_d = 32'(edgesel_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            stable_q   <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            edgesel_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q   <= stable_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            edgesel_q  <= edgesel_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

    // Upper write-data bits have no storage behind them
    if (WIDTH < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner: register table, directed
// corner-case sequences and randomized traffic against a sample-window model.
module tb_gpio_input_conditioner;

    localparam int WIDTH = 28;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int HLEN  = SYNC + DEB;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] pin_in;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             irq;

    gpio_input_conditioner #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a pin change is accepted once the last DEB synchronized
    // samples all differ from the accepted level; sync sample = pin seen SYNC edges ago.
    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] m_stable, m_cap, m_mask, m_sel;
    logic [31:0]      m_rd;
    logic             m_irq;

    function automatic void model_reset();
        hist.delete();
        for (int j = 0; j < HLEN; j++) hist.push_back('0);
        m_stable = '0; m_cap = '0; m_mask = '0; m_sel = '0;
        m_rd = '0; m_irq = 1'b0;
    endfunction

    function automatic void model_edge(input logic [1:0] a, input logic c, input logic w,
                                       input logic [31:0] d, input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] acc, nst, set, clr;
        logic [31:0] rd;
        hist.push_back(p);
        if (hist.size() > HLEN) void'(hist.pop_front());
        acc = '1;
        for (int j = 0; j < DEB; j++) acc &= hist[j] ^ m_stable;
        nst = m_stable ^ acc;
        set = (acc & nst & ~m_sel) | (acc & ~nst & m_sel);
        clr = (c && !w && a == 2'd1) ? d[WIDTH-1:0] : '0;
        case (a)
            2'd0:    rd = {4'h0, m_stable};
            2'd1:    rd = {4'h0, m_cap};
            2'd2:    rd = {4'h0, m_mask};
            default: rd = {4'h0, m_sel};
        endcase
        m_rd  = rd;
        m_irq = |(m_cap & m_mask);
        m_cap = (m_cap & ~clr) | set;
        if (c && !w && a == 2'd2) m_mask = d[WIDTH-1:0];
        if (c && !w && a == 2'd3) m_sel  = d[WIDTH-1:0];
        m_stable = nst;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] a, input logic c, input logic w,
                        input logic [31:0] d, input logic [WIDTH-1:0] p);
        address = a; chipselect = c; write_n = w; writedata = d; pin_in = p;
        @(posedge clk);
        #1;
        model_edge(a, c, w, d, p);
        chk("model_readdata", readdata, m_rd);
        chk("model_irq", 32'(irq), 32'(m_irq));
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [10];
    logic [WIDTH-1:0] rp;

    initial begin
        tbl[0] = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[1] = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, 32'h0FFF_FFFF, 1'b0};
        tbl[2] = '{2'd3, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[3] = '{2'd3, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[4] = '{2'd0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[5] = '{2'd1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[6] = '{2'd2, 1'b1, 1'b0, 32'h0000_0000, 32'h0FFF_FFFF, 1'b0};
        tbl[7] = '{2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[8] = '{2'd3, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[9] = '{2'd3, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

        reset_n = 1'b0; pin_in = '0; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // Register readback table
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd, '0);
            chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end

        // Clean rise on pin 3: accepted on the 6th edge, visible in readdata one edge later
        repeat (6) step(2'd0, 1'b0, 1'b1, 0, 28'h8);
        chk("A_state_pre", readdata, 32'h0);
        step(2'd0, 1'b0, 1'b1, 0, 28'h8);
        chk("A_state", readdata, 32'h8);
        step(2'd1, 1'b0, 1'b1, 0, 28'h8);
        chk("A_cap", readdata, 32'h8);
        chk("A_irq", 32'(irq), 32'h0);

        // Glitch rejection then a just-long-enough pulse on pin 5
        repeat (3) step(2'd0, 1'b0, 1'b1, 0, 28'h28);
        repeat (10) step(2'd0, 1'b0, 1'b1, 0, 28'h08);
        chk("B_glitch_state", readdata, 32'h08);
        step(2'd1, 1'b0, 1'b1, 0, 28'h08);
        chk("B_glitch_cap", readdata, 32'h08);
        repeat (4) step(2'd0, 1'b0, 1'b1, 0, 28'h28);
        repeat (3) step(2'd0, 1'b0, 1'b1, 0, 28'h08);
        chk("B_pulse_rise", readdata, 32'h28);
        repeat (6) step(2'd0, 1'b0, 1'b1, 0, 28'h08);
        chk("B_pulse_fall", readdata, 32'h08);
        step(2'd1, 1'b0, 1'b1, 0, 28'h08);
        chk("B_pulse_cap", readdata, 32'h28);

        // Interrupt path
        step(2'd1, 1'b1, 1'b0, 32'h28, 28'h8);
        step(2'd2, 1'b1, 1'b0, 32'h8, 28'h8);
        repeat (8) step(2'd0, 1'b0, 1'b1, 0, 28'h0);
        repeat (6) step(2'd0, 1'b0, 1'b1, 0, 28'h8);
        chk("C_irq_pre", 32'(irq), 32'h0);
        step(2'd0, 1'b0, 1'b1, 0, 28'h8);
        chk("C_irq_set", 32'(irq), 32'h1);
        step(2'd1, 1'b1, 1'b0, 32'h0, 28'h8);
        chk("C_w0_cap", readdata, 32'h8);
        step(2'd1, 1'b1, 1'b0, 32'h8, 28'h8);
        chk("C_irq_hold", 32'(irq), 32'h1);
        step(2'd1, 1'b0, 1'b1, 0, 28'h8);
        chk("C_clr_cap", readdata, 32'h0);
        chk("C_clr_irq", 32'(irq), 32'h0);

        // Falling-edge select on pin 0
        step(2'd3, 1'b1, 1'b0, 32'h1, 28'h8);
        repeat (8) step(2'd0, 1'b0, 1'b1, 0, 28'h9);
        repeat (8) step(2'd0, 1'b0, 1'b1, 0, 28'h8);
        step(2'd1, 1'b0, 1'b1, 0, 28'h8);
        chk("D_fall_cap", readdata, 32'h1);
        step(2'd1, 1'b1, 1'b0, 32'h1, 28'h8);
        repeat (8) step(2'd0, 1'b0, 1'b1, 0, 28'h9);
        step(2'd1, 1'b0, 1'b1, 0, 28'h9);
        chk("D_rise_nocap", readdata, 32'h0);

        // W1C of bit 3 on the same edge as a new accept on bit 3
        step(2'd3, 1'b1, 1'b0, 32'h0, 28'h9);
        repeat (8) step(2'd0, 1'b0, 1'b1, 0, 28'h1);
        repeat (5) step(2'd0, 1'b0, 1'b1, 0, 28'h9);
        step(2'd1, 1'b1, 1'b0, 32'h8, 28'h9);
        step(2'd1, 1'b0, 1'b1, 0, 28'h9);
        chk("E_collide", readdata, 32'h8);

        // Asynchronous reset two cycles into a pending change
        step(2'd0, 1'b0, 1'b1, 0, 28'h89);
        step(2'd2, 1'b0, 1'b1, 0, 28'h89);
        chk("F_pre_rd", readdata, 32'h8);
        chk("F_pre_irq", 32'(irq), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("F_rst_rd", readdata, 32'h0);
        chk("F_rst_irq", 32'(irq), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(2'd1, 1'b0, 1'b1, 0, 28'h89);
        chk("F_cap", readdata, 32'h0);
        step(2'd2, 1'b0, 1'b1, 0, 28'h89);
        chk("F_mask", readdata, 32'h0);
        step(2'd3, 1'b0, 1'b1, 0, 28'h89);
        chk("F_sel", readdata, 32'h0);

        // Randomized traffic: slowly wandering pins with occasional glitches
        rp = 28'h89;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) rp = rp ^ (28'(1) << $urandom_range(0, WIDTH-1));
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), $urandom, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
